// File: rtl/decoder_arbiter_8.sv
// Round-robin owner of a shared 8-way decoder: one-cycle request-to-grant, forced release after MAX_HOLD.
// Ownership changes always pass through a one-cycle dead gap with Enable low.
module decoder_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Req,
    output logic       Enable,
    output logic [2:0] Sel,
    output logic [7:0] Grant,
    output logic       Busy,
    output logic       Preempt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // With preemption disabled the counter simply saturates at all-ones.
    localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD != 0) ? HOLD_W'(MAX_HOLD) : '1;

    state_t            state, state_nxt;
    logic [2:0]        sel_nxt;
    logic [2:0]        ptr, ptr_nxt;
    logic [HOLD_W-1:0] hold, hold_nxt;
    logic              preempt_nxt;

    logic              win_vld;
    logic [2:0]        win_idx;
    logic [2:0]        scan_idx;
    logic              owner_req;
    logic              others_req;

    // Scan from the farthest slot back toward ptr so the closest requester wins.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = ptr;
        scan_idx = ptr;
        for (int k = 7; k >= 0; k--) begin
            scan_idx = ptr + 3'(k);
            if (Req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    assign owner_req  = Req[Sel];
    assign others_req = |(Req & ~(8'd1 << Sel));

    always_comb begin
        state_nxt   = state;
        sel_nxt     = Sel;
        ptr_nxt     = ptr;
        hold_nxt    = hold;
        preempt_nxt = 1'b0;
        case (state)
            S_IDLE, S_GAP: begin
                if (win_vld) begin
                    state_nxt = S_GRANT;
                    sel_nxt   = win_idx;
                    hold_nxt  = HOLD_W'(1);
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                if (!owner_req) begin
                    state_nxt = S_GAP;
                    ptr_nxt   = Sel + 3'd1;
                end else if ((MAX_HOLD != 0) && (hold == HOLD_SAT) && others_req) begin
                    state_nxt   = S_GAP;
                    ptr_nxt     = Sel + 3'd1;
                    preempt_nxt = 1'b1;
                end else if (hold != HOLD_SAT) begin
                    hold_nxt = hold + HOLD_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_IDLE;
            Sel     <= 3'd0;
            ptr     <= 3'd0;
            hold    <= '0;
            Preempt <= 1'b0;
        end else begin
            state   <= state_nxt;
            Sel     <= sel_nxt;
            ptr     <= ptr_nxt;
            hold    <= hold_nxt;
            Preempt <= preempt_nxt;
        end
    end

    // Decoded purely from registers, so no path from Req reaches these pins.
    assign Enable = (state == S_GRANT);
    assign Busy   = (state != S_IDLE);
    assign Grant  = Enable ? (8'd1 << Sel) : 8'd0;

endmodule

// File: tb/tb_decoder_arbiter_8.sv
// Directed bench for decoder_arbiter_8: reset, single grant, wrap, preemption, lone holder, reset mid-grant.
module tb_decoder_arbiter_8;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] Req;
    logic       Enable;
    logic [2:0] Sel;
    logic [7:0] Grant;
    logic       Busy;
    logic       Preempt;

    int checks = 0;
    int errors = 0;

    decoder_arbiter_8 #(.MAX_HOLD(16), .HOLD_W(5)) u_dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Req    (Req),
        .Enable (Enable),
        .Sel    (Sel),
        .Grant  (Grant),
        .Busy   (Busy),
        .Preempt(Preempt)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(negedge Clock);
        chk("inv_enable", {31'd0, Enable}, {31'd0, |Grant});
        chk("inv_onehot", {31'd0, $countones(Grant) <= 1}, 32'd1);
    endtask

    task automatic expect_state(input string tag, input logic [7:0] g, input logic b, input logic p);
        chk({tag, "_grant"}, {24'd0, Grant}, {24'd0, g});
        chk({tag, "_busy"}, {31'd0, Busy}, {31'd0, b});
        chk({tag, "_preempt"}, {31'd0, Preempt}, {31'd0, p});
    endtask

    initial begin
        // T1: reset with all requests raised
        Reset = 1'b1;
        Req   = 8'hFF;
        step();
        step();
        expect_state("t1_rst", 8'h00, 1'b0, 1'b0);
        chk("t1_rst_en", {31'd0, Enable}, 32'd0);
        chk("t1_rst_sel", {29'd0, Sel}, 32'd0);
        Reset = 1'b0;
        step();
        expect_state("t1_first", 8'h01, 1'b1, 1'b0);
        Req = 8'h00;
        step();
        expect_state("t1_gap", 8'h00, 1'b1, 1'b0);
        step();
        expect_state("t1_idle", 8'h00, 1'b0, 1'b0);

        // T2: single requester 3 (ptr now 1)
        Req = 8'h08;
        step();
        expect_state("t2_grant", 8'h08, 1'b1, 1'b0);
        chk("t2_sel", {29'd0, Sel}, 32'd3);
        chk("t2_en", {31'd0, Enable}, 32'd1);
        Req = 8'h00;
        step();
        expect_state("t2_gap", 8'h00, 1'b1, 1'b0);
        chk("t2_gap_sel", {29'd0, Sel}, 32'd3);
        step();
        expect_state("t2_idle", 8'h00, 1'b0, 1'b0);

        // T3: ptr=4, requesters 7 and 0 -> 7 first, then wrap to 0
        Req = 8'h81;
        step();
        expect_state("t3_own7", 8'h80, 1'b1, 1'b0);
        chk("t3_sel7", {29'd0, Sel}, 32'd7);
        Req = 8'h01;
        step();
        expect_state("t3_gap", 8'h00, 1'b1, 1'b0);
        step();
        expect_state("t3_wrap", 8'h01, 1'b1, 1'b0);

        // T4: preemption between 0 and 2, starting from ptr=0 after reset
        Reset = 1'b1;
        Req   = 8'h00;
        step();
        expect_state("t4_rst", 8'h00, 1'b0, 1'b0);
        Reset = 1'b0;
        Req   = 8'h05;
        for (int i = 0; i < 16; i++) begin
            step();
            expect_state("t4_own0", 8'h01, 1'b1, 1'b0);
        end
        step();
        expect_state("t4_pre0", 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step();
            expect_state("t4_own2", 8'h04, 1'b1, 1'b0);
        end
        step();
        expect_state("t4_pre2", 8'h00, 1'b1, 1'b1);
        step();
        expect_state("t4_back0", 8'h01, 1'b1, 1'b0);

        // T5: lone holder is never preempted
        Req = 8'h10;
        step();
        expect_state("t5_gap", 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step();
            expect_state("t5_hold", 8'h10, 1'b1, 1'b0);
        end
        chk("t5_hold_cnt", {27'd0, u_dut.hold}, 32'd16);

        // T6: reset while requester 2 owns
        Req = 8'h04;
        step();
        expect_state("t6_gap", 8'h00, 1'b1, 1'b0);
        step();
        expect_state("t6_own2", 8'h04, 1'b1, 1'b0);
        Reset = 1'b1;
        step();
        expect_state("t6_rst", 8'h00, 1'b0, 1'b0);
        chk("t6_rst_sel", {29'd0, Sel}, 32'd0);
        Reset = 1'b0;
        Req   = 8'h05;
        step();
        expect_state("t6_own0", 8'h01, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
